uart_rx_buffered: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo_fwft.sv | 67 ++++++
 rtl/uart_rx_buffered.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE = 16;

  // Clocks per oversample tick; never below one so the tick stays alive.
  function automatic int baud_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: the head word is presented on pop_data
// while the FIFO is non-empty; count, empty and full are registered.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  do_push;
  logic                  do_pop;

  // A push while full only proceeds when a pop frees the head slot.
  always_comb begin
    do_pop      = pop && !empty;
    do_push     = push && (!full || do_pop);
    rd_ptr_next = do_pop ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
    count_next  = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_next = count - (ADDR_WIDTH + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      empty  <= (count_next == '0);
      full   <= (count_next == (ADDR_WIDTH + 1)'(DEPTH));
      // Bypass when the word being written lands in the new head slot.
      if (count_next != '0) begin
        if (do_push && (wr_ptr == rd_ptr_next)) pop_data <= push_data;
        else                                    pop_data <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (16x oversampled, optional parity) feeding a show-ahead
// receive FIFO, with sticky frame/parity/overrun error flags.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun,
  input  logic                  clr_err,
  output logic [2:0]            state_dbg
);

  // pop is a take strobe: the word on pop_data is consumed on any clock
  // with pop && !empty. Received words have no back-pressure; a good frame
  // arriving while full (and not popped that cycle) is dropped as overrun.

  localparam int             DIV      = baud_div(CLK_FREQ, BAUD);
  localparam int             TW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam parity_e        PAR_MODE = parity_e'(PARITY[1:0]);
  localparam logic [3:0]     LAST_BIT = 4'(DATA_WIDTH - 1);

  logic [TW-1:0]         div_cnt;
  logic                  tick;
  logic                  rx_s1;
  logic                  rx_sync;
  logic                  rx_prev;
  rx_state_e             state;
  logic [3:0]            os_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_bad;

  // Free-running oversample tick, deliberately not re-phased by start edges.
  assign tick = (div_cnt == TW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      // Clearing first lets a same-cycle error event override it below.
      if (clr_err) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state  <= ST_START;
            os_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              par_bad <= 1'b0;
              state   <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT)
                state <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              par_bad <= (^{shift_reg, rx_sync}) != (PAR_MODE == PAR_ODD);
              state   <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              state <= ST_IDLE;
              if (!rx_sync)     frame_err  <= 1'b1;
              else if (par_bad) parity_err <= 1'b1;
              else              rx_done    <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // shift_reg is stable until the next frame's first data sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     overrun <= 1'b0;
    else if (rx_done && full && !pop) overrun <= 1'b1;
    else if (clr_err)                 overrun <= 1'b0;
  end

  assign state_dbg = state;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_done),
    .push_data (shift_reg),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule
